rs_alu_gen: RTL and testbench
=============================

Name: rs_alu_gen

Overview:
- Parametrised successor of the two-entry ALU reservation station for the o3cpu Tomasulo core.
- Holds up to RS_ENTRY_NUM issued ALU ops and snoops the common data bus (CDB) for missing operands.
- Selects the oldest ready entry and dispatches it to the ALU under a valid/ready handshake.
- Supports a pipeline flush on branch mispredict.
- Sits between issue/rename and the ALU function unit.

Parameters:
- RS_ENTRY_NUM, 4: entry count, 2..16.
- ROB_ENTRY_WIDTH, 8: ROB tag width.
- OP_WIDTH, 6: opcode width.
- DATA_WIDTH, 32: operand/immediate width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- full  out  1  all entries busy.
- issue_valid  in  1  issue request.
- Op_in  in  OP_WIDTH  operation.
- Vj_in, Vk_in  in  DATA_WIDTH  source values, valid when Rj_in/Rk_in = 1.
- Rj_in, Rk_in  in  1  source ready flags.
- Qj_in, Qk_in  in  ROB_ENTRY_WIDTH  producing ROB tag when not ready.
- Dest_in  in  ROB_ENTRY_WIDTH  destination ROB tag.
- A_in  in  DATA_WIDTH  immediate.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_ENTRY_WIDTH  CDB ROB tag.
- cdb_data  in  DATA_WIDTH  CDB result.
- disp_valid  out  1  dispatch candidate present.
- disp_ready  in  1  ALU accepts.
- Op_out  out  OP_WIDTH  dispatched operation.
- Vj_out, Vk_out  out  DATA_WIDTH  dispatched operands.
- A_out  out  DATA_WIDTH  dispatched immediate.
- Dest_out  out  ROB_ENTRY_WIDTH  dispatched destination tag.
- flush  in  1  discard all entries.

Behaviour:
- Per-entry state: Busy, Op, Vj, Vk, Rj, Rk, Qj, Qk, Dest, A, age rank (clog2(RS_ENTRY_NUM) bits).
- Reset (rst low, async): all Busy, Rj, Rk and rank fields cleared. Outputs: full=0, disp_valid=0, all data outputs 0.
- full = AND of Busy, combinational from registers.
- Issue accepted when issue_valid && !full && !flush:
  - Written into the lowest-index free entry at the clock edge.
  - rank = number of busy entries after this cycle's dispatch removal.
- A slot freed by dispatch in the same cycle does not enable issue; full reflects start-of-cycle state.
- Issue with full=1: request ignored, no state change; the issue stage holds.
- Issue-time CDB capture: if cdb_valid && !Rj_in && cdb_tag == Qj_in, the entry stores Vj=cdb_data and Rj=1 directly. Same rule for k.
- Wake-up: every busy entry with Rx=0 and Qx == cdb_tag under cdb_valid sets Vx=cdb_data, Rx=1 at the edge. j and k may wake in the same cycle.
- Ready = Busy && Rj && Rk, evaluated on registered state. An entry woken this cycle becomes ready next cycle, one-cycle wake-up-to-dispatch latency.
- Select: ready entry with lowest rank (oldest); ties are impossible.
  - disp_valid = any ready && !flush.
  - Outputs show the selected entry combinationally; all zero when disp_valid=0.
- Dispatch handshake:
  - On disp_valid && disp_ready, the selected entry clears Busy at the edge.
  - Every entry with larger rank decrements its rank.
  - Without disp_ready, outputs hold and may switch only if an older entry becomes ready.
- Simultaneous issue + dispatch: rank of the new entry = (busy count − 1); remaining ranks stay contiguous 0..n−1.
- Flush:
  - Clears all Busy at the edge and takes priority over issue and dispatch.
  - disp_valid is forced 0 during the flush cycle.
  - CDB is ignored during flush.
- Rank invariant: busy entries always hold unique ranks 0..(count−1).

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry missing only operands delivered by this cycle's CDB counts as ready.
  - Vj_out/Vk_out are forwarded from cdb_data, giving zero-cycle wake-up-to-dispatch.
  - Oldest-first selection still applies.
- Undefined: the one-cycle wake-up latency above applies.

Decomposition:
- Package o3_pkg:
  - ROB_ENTRY_WIDTH, OP_WIDTH and DATA_WIDTH defaults.
  - rs_entry_t struct.
  - cdb_t struct (valid, tag, data).
- Sub-module rs_age_select: takes the ready vector and rank array, returns a one-hot grant and a valid flag.

Test Plan:
- Reset: hold rst low 3 cycles, check full=0, disp_valid=0, Op_out=0. Issue 1 ready op (Op=6'h01, Vj=5, Vk=7, Dest=3) -> disp_valid=1, Dest_out=3 the next cycle; entry freed after the disp_ready edge.
- Fill: issue 4 ops with Rj=0, Qj=9 -> full=1 after the 4th. A 5th issue is ignored. CDB tag 9 data 0x55 -> all 4 Vj=0x55; disp_valid=1 the following cycle, oldest (first issued) Dest_out first.
- Age order: issue A (waits tag 2), B (ready), C (waits tag 2), hold disp_ready=0. Dispatch B; CDB tag 2 -> A dispatched before C.
- Issue-time capture: issue with Qk_in=5 while CDB broadcasts tag 5 data 0xABCD -> Vk_out=0xABCD, dispatch the next cycle.
- Flush: 3 busy entries plus issue_valid and disp_ready in the flush cycle -> next cycle full=0, disp_valid=0, nothing dispatched. Assert rst mid-operation -> immediate clear.
- RS_WAKEUP_BYPASS_EN: op waiting on tag 4, CDB tag 4 data 0x10 -> disp_valid=1 the same cycle, Vj_out=0x10.

Source files
------------

// File: rtl/o3_pkg.sv
// o3_pkg: shared default widths and bundles for the o3cpu reservation stations.
// Widths here are the defaults; parametrised modules build local types from them.
package o3_pkg;

    localparam int DEF_ROB_ENTRY_WIDTH = 8;
    localparam int DEF_OP_WIDTH        = 6;
    localparam int DEF_DATA_WIDTH      = 32;

    typedef struct packed {
        logic                           busy;
        logic [DEF_OP_WIDTH-1:0]        op;
        logic [DEF_DATA_WIDTH-1:0]      vj;
        logic [DEF_DATA_WIDTH-1:0]      vk;
        logic                           rj;
        logic                           rk;
        logic [DEF_ROB_ENTRY_WIDTH-1:0] qj;
        logic [DEF_ROB_ENTRY_WIDTH-1:0] qk;
        logic [DEF_ROB_ENTRY_WIDTH-1:0] dest;
        logic [DEF_DATA_WIDTH-1:0]      a;
    } rs_entry_t;

    typedef struct packed {
        logic                           valid;
        logic [DEF_ROB_ENTRY_WIDTH-1:0] tag;
        logic [DEF_DATA_WIDTH-1:0]      data;
    } cdb_t;

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: grants the ready entry holding the lowest age rank.
// Ranks of busy entries are unique, so the grant is one-hot.
module rs_age_select #(
    parameter int N  = 4,
    parameter int RW = 2
) (
    input  logic [N-1:0]         ready,
    input  logic [N-1:0][RW-1:0] rank,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && rank[j] <= rank[i])
                    grant[i] = 1'b0;
            end
        end
        valid = |ready;
    end

endmodule

// File: rtl/rs_alu_gen.sv
// rs_alu_gen: N-entry ALU reservation station with CDB snoop and oldest-first issue.
// Define RS_WAKEUP_BYPASS_EN to let same-cycle CDB results make an entry dispatchable.
module rs_alu_gen
    import o3_pkg::*;
#(
    parameter int RS_ENTRY_NUM    = 4,
    parameter int ROB_ENTRY_WIDTH = DEF_ROB_ENTRY_WIDTH,
    parameter int OP_WIDTH        = DEF_OP_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       full,
    input  logic                       issue_valid,
    input  logic [OP_WIDTH-1:0]        Op_in,
    input  logic [DATA_WIDTH-1:0]      Vj_in,
    input  logic [DATA_WIDTH-1:0]      Vk_in,
    input  logic                       Rj_in,
    input  logic                       Rk_in,
    input  logic [ROB_ENTRY_WIDTH-1:0] Qj_in,
    input  logic [ROB_ENTRY_WIDTH-1:0] Qk_in,
    input  logic [ROB_ENTRY_WIDTH-1:0] Dest_in,
    input  logic [DATA_WIDTH-1:0]      A_in,
    input  logic                       cdb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] cdb_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_data,
    output logic                       disp_valid,
    input  logic                       disp_ready,
    output logic [OP_WIDTH-1:0]        Op_out,
    output logic [DATA_WIDTH-1:0]      Vj_out,
    output logic [DATA_WIDTH-1:0]      Vk_out,
    output logic [DATA_WIDTH-1:0]      A_out,
    output logic [ROB_ENTRY_WIDTH-1:0] Dest_out,
    input  logic                       flush
);

    localparam int N  = RS_ENTRY_NUM;
    localparam int RW = $clog2(N);
    localparam int CW = RW + 1;

    typedef struct packed {
        logic                       busy;
        logic [OP_WIDTH-1:0]        op;
        logic [DATA_WIDTH-1:0]      vj;
        logic [DATA_WIDTH-1:0]      vk;
        logic                       rj;
        logic                       rk;
        logic [ROB_ENTRY_WIDTH-1:0] qj;
        logic [ROB_ENTRY_WIDTH-1:0] qk;
        logic [ROB_ENTRY_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]      a;
    } ent_t;

    ent_t                 ent_q [N];
    ent_t                 ent_d [N];
    logic [N-1:0][RW-1:0] rank_q;
    logic [N-1:0][RW-1:0] rank_d;

    logic [N-1:0]  busy;
    logic [N-1:0]  hit_j;
    logic [N-1:0]  hit_k;
    logic [N-1:0]  ready;
    logic [N-1:0]  grant;
    logic          sel_any;
    logic          fire;
    logic          issue_ok;
    logic          cap_j;
    logic          cap_k;
    logic [RW-1:0] free_idx;
    logic [RW-1:0] sel_rank;
    logic [RW-1:0] new_rank;
    logic [CW-1:0] cnt;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            busy[i]  = ent_q[i].busy;
            hit_j[i] = cdb_valid && !ent_q[i].rj
                    && ent_q[i].qj == cdb_tag;
            hit_k[i] = cdb_valid && !ent_q[i].rk
                    && ent_q[i].qk == cdb_tag;
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = busy[i]
                    && (ent_q[i].rj || hit_j[i])
                    && (ent_q[i].rk || hit_k[i]);
`else
            ready[i] = busy[i] && ent_q[i].rj && ent_q[i].rk;
`endif
        end
    end

    rs_age_select #(
        .N  (N),
        .RW (RW)
    ) u_sel (
        .ready (ready),
        .rank  (rank_q),
        .grant (grant),
        .valid (sel_any)
    );

    assign full       = &busy;
    assign disp_valid = sel_any && !flush;
    assign fire       = disp_valid && disp_ready;
    assign issue_ok   = issue_valid && !full && !flush;
    assign cap_j      = cdb_valid && !Rj_in && cdb_tag == Qj_in;
    assign cap_k      = cdb_valid && !Rk_in && cdb_tag == Qk_in;

    // Descending scan leaves the lowest free index in free_idx.
    always_comb begin
        cnt      = '0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cnt = cnt + CW'(busy[i]);
            if (!busy[i])
                free_idx = RW'(i);
        end
        new_rank = RW'(cnt - CW'(fire));
    end

    always_comb begin
        Op_out   = '0;
        Vj_out   = '0;
        Vk_out   = '0;
        A_out    = '0;
        Dest_out = '0;
        sel_rank = '0;
        for (int i = 0; i < N; i++) begin
            if (disp_valid && grant[i]) begin
                Op_out   = ent_q[i].op;
                Vj_out   = ent_q[i].vj;
                Vk_out   = ent_q[i].vk;
                A_out    = ent_q[i].a;
                Dest_out = ent_q[i].dest;
                sel_rank = rank_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
                if (!ent_q[i].rj)
                    Vj_out = cdb_data;
                if (!ent_q[i].rk)
                    Vk_out = cdb_data;
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_d[i]  = ent_q[i];
            rank_d[i] = rank_q[i];
            if (flush) begin
                ent_d[i].busy = 1'b0;
                ent_d[i].rj   = 1'b0;
                ent_d[i].rk   = 1'b0;
                rank_d[i]     = '0;
            end else if (ent_q[i].busy) begin
                if (hit_j[i]) begin
                    ent_d[i].vj = cdb_data;
                    ent_d[i].rj = 1'b1;
                end
                if (hit_k[i]) begin
                    ent_d[i].vk = cdb_data;
                    ent_d[i].rk = 1'b1;
                end
                if (fire && grant[i])
                    ent_d[i].busy = 1'b0;
                else if (fire && rank_q[i] > sel_rank)
                    rank_d[i] = rank_q[i] - RW'(1);
            end else if (issue_ok && free_idx == RW'(i)) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = Op_in;
                ent_d[i].vj   = cap_j ? cdb_data : Vj_in;
                ent_d[i].vk   = cap_k ? cdb_data : Vk_in;
                ent_d[i].rj   = Rj_in || cap_j;
                ent_d[i].rk   = Rk_in || cap_k;
                ent_d[i].qj   = Qj_in;
                ent_d[i].qk   = Qk_in;
                ent_d[i].dest = Dest_in;
                ent_d[i].a    = A_in;
                rank_d[i]     = new_rank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                ent_q[i] <= '0;
            rank_q <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                ent_q[i] <= ent_d[i];
            rank_q <= rank_d;
        end
    end

endmodule

// File: tb/tb_rs_alu_gen.sv
// tb_rs_alu_gen: directed vector table, reset/bypass sequences and a
// randomized run checked against an age-ordered queue model.
module tb_rs_alu_gen;

`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        full;
    logic        issue_valid;
    logic [5:0]  Op_in;
    logic [31:0] Vj_in, Vk_in, A_in;
    logic        Rj_in, Rk_in;
    logic [7:0]  Qj_in, Qk_in, Dest_in;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  Op_out;
    logic [31:0] Vj_out, Vk_out, A_out;
    logic [7:0]  Dest_out;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rs_alu_gen dut (
        .clk         (clk),
        .rst         (rst),
        .full        (full),
        .issue_valid (issue_valid),
        .Op_in       (Op_in),
        .Vj_in       (Vj_in),
        .Vk_in       (Vk_in),
        .Rj_in       (Rj_in),
        .Rk_in       (Rk_in),
        .Qj_in       (Qj_in),
        .Qk_in       (Qk_in),
        .Dest_in     (Dest_in),
        .A_in        (A_in),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .Op_out      (Op_out),
        .Vj_out      (Vj_out),
        .Vk_out      (Vk_out),
        .A_out       (A_out),
        .Dest_out    (Dest_out),
        .flush       (flush)
    );

    typedef struct {
        logic        iv;
        logic [5:0]  op;
        logic [31:0] vj, vk;
        logic        rj, rk;
        logic [7:0]  qj, qk, dest;
        logic        cv;
        logic [7:0]  ct;
        logic [31:0] cd;
        logic        dr, fl;
        logic        ef, edv;
        logic [5:0]  eop;
        logic [7:0]  edest;
        logic [31:0] evj, evk;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, a;
        logic        rj, rk;
        logic [7:0]  qj, qk, dest;
    } m_t;

    vec_t vt[$];
    vec_t v;
    m_t   mq[$];

    function automatic vec_t blank();
        vec_t r;
        r = '{default: '0};
        return r;
    endfunction

    task automatic is_op(input logic [5:0] op,
                         input logic [31:0] vj, vk,
                         input logic rj, rk,
                         input logic [7:0] qj, qk, dest);
        v.iv = 1'b1; v.op = op; v.vj = vj; v.vk = vk;
        v.rj = rj; v.rk = rk; v.qj = qj; v.qk = qk;
        v.dest = dest;
    endtask

    task automatic cdb(input logic [7:0] t, input logic [31:0] d);
        v.cv = 1'b1; v.ct = t; v.cd = d;
    endtask

    task automatic ex(input logic f, dv, input logic [5:0] op,
                      input logic [7:0] dest,
                      input logic [31:0] vj, vk);
        v.ef = f; v.edv = dv; v.eop = op; v.edest = dest;
        v.evj = vj; v.evk = vk;
    endtask

    task automatic row();
        vt.push_back(v);
        v = blank();
    endtask

    task automatic drive(input vec_t r);
        issue_valid = r.iv; Op_in = r.op;
        Vj_in = r.vj; Vk_in = r.vk;
        Rj_in = r.rj; Rk_in = r.rk;
        Qj_in = r.qj; Qk_in = r.qk;
        Dest_in = r.dest;
        A_in = 32'hA0 + {24'h0, r.dest};
        cdb_valid = r.cv; cdb_tag = r.ct; cdb_data = r.cd;
        disp_ready = r.dr; flush = r.fl;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ef, edv,
                           input logic [5:0] eop,
                           input logic [7:0] edest,
                           input logic [31:0] evj, evk, ea);
        chk({nm, " full"}, 64'(full), 64'(ef));
        chk({nm, " disp_valid"}, 64'(disp_valid), 64'(edv));
        chk({nm, " op/dest"}, {50'h0, Op_out, Dest_out},
            {50'h0, eop, edest});
        chk({nm, " vj"}, 64'(Vj_out), 64'(evj));
        chk({nm, " vk"}, 64'(Vk_out), 64'(evk));
        chk({nm, " a"}, 64'(A_out), 64'(ea));
    endtask

    task automatic apply(input int k, input vec_t r);
        logic [31:0] ea;
        @(negedge clk);
        drive(r);
        #1;
        ea = r.edv ? 32'hA0 + {24'h0, r.edest} : 32'h0;
        chk_out($sformatf("row%0d", k), r.ef, r.edv, r.eop,
                r.edest, r.evj, r.evk, ea);
    endtask

    task automatic step(input vec_t r);
        @(negedge clk);
        drive(r);
    endtask

    initial begin
        vec_t r;
        int   sel;
        logic e_dv, e_f, rdy, ok_iss;
        logic [31:0] e_vj, e_vk;
        m_t   e, ne;

        v = blank();
        rst = 1'b0;
        drive(blank());
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset state and single ready op
        ex(0, 0, 0, 0, 0, 0); row();
        is_op(1, 5, 7, 1, 1, 0, 0, 3); row();
        ex(0, 1, 1, 3, 5, 7); row();
        v.dr = 1; ex(0, 1, 1, 3, 5, 7); row();
        row();
        // fill, ignored 5th issue, broadcast wake-up
        for (int k = 0; k < 4; k++) begin
            is_op(6'(2 + k), 0, 32'(16 + k), 0, 1, 9, 0, 8'(10 + k));
            row();
        end
        is_op(6, 1, 1, 1, 1, 0, 0, 14); ex(1, 0, 0, 0, 0, 0); row();
        cdb(9, 'h55);
        if (BYP) ex(1, 1, 2, 10, 'h55, 16);
        else ex(1, 0, 0, 0, 0, 0);
        row();
        v.dr = 1; ex(1, 1, 2, 10, 'h55, 16); row();
        v.dr = 1; ex(0, 1, 3, 11, 'h55, 17); row();
        v.dr = 1; ex(0, 1, 4, 12, 'h55, 18); row();
        v.dr = 1; ex(0, 1, 5, 13, 'h55, 19); row();
        row();
        // age order
        is_op(7, 0, 1, 0, 1, 2, 0, 20); row();
        is_op(8, 2, 3, 1, 1, 0, 0, 21); row();
        is_op(9, 0, 4, 0, 1, 2, 0, 22); ex(0, 1, 8, 21, 2, 3); row();
        v.dr = 1; ex(0, 1, 8, 21, 2, 3); row();
        cdb(2, 'h77);
        if (BYP) ex(0, 1, 7, 20, 'h77, 1);
        else ex(0, 0, 0, 0, 0, 0);
        row();
        v.dr = 1; ex(0, 1, 7, 20, 'h77, 1); row();
        v.dr = 1; ex(0, 1, 9, 22, 'h77, 4); row();
        row();
        // issue-time capture
        is_op(10, 1, 0, 1, 0, 0, 5, 30); cdb(5, 'hABCD); row();
        v.dr = 1; ex(0, 1, 10, 30, 1, 'hABCD); row();
        row();
        // flush with issue, dispatch and CDB in the same cycle
        is_op(11, 1, 2, 1, 1, 0, 0, 40); row();
        is_op(12, 3, 4, 1, 1, 0, 0, 41); ex(0, 1, 11, 40, 1, 2); row();
        is_op(13, 5, 6, 1, 1, 0, 0, 42); ex(0, 1, 11, 40, 1, 2); row();
        is_op(14, 7, 8, 1, 1, 0, 0, 43); cdb(1, 'h99);
        v.dr = 1; v.fl = 1; row();
        v.dr = 1; row();
        row();

        for (int k = 0; k < vt.size(); k++)
            apply(k, vt[k]);

        // async reset while full
        for (int k = 0; k < 4; k++) begin
            r = blank();
            r.iv = 1; r.rj = 1; r.rk = 1;
            r.op = 6'(20 + k); r.dest = 8'(50 + k);
            step(r);
        end
        step(blank());
        #1;
        chk("rstseq full", 64'(full), 64'(1));
        chk("rstseq dest", 64'(Dest_out), 64'(50));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstseq full0", 64'(full), 64'(0));
        chk("rstseq dv0", 64'(disp_valid), 64'(0));
        chk("rstseq op0", 64'(Op_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // same-cycle wake-up latency
        r = blank();
        r.iv = 1; r.op = 15; r.rk = 1; r.vk = 3;
        r.qj = 4; r.dest = 60;
        step(r);
        r = blank();
        r.cv = 1; r.ct = 4; r.cd = 'h10;
        step(r);
        #1;
        chk("byp dv", 64'(disp_valid), 64'(BYP));
        chk("byp vj", 64'(Vj_out), BYP ? 64'h10 : 64'h0);
        r = blank();
        r.dr = 1;
        step(r);
        #1;
        chk("byp2 dv", 64'(disp_valid), 64'(1));
        chk("byp2 vj", 64'(Vj_out), 64'h10);
        step(blank());
        #1;
        chk("byp3 dv", 64'(disp_valid), 64'(0));

        // randomized run against the queue model
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            r = blank();
            r.iv = 1'($urandom_range(0, 1));
            r.op = 6'($urandom);
            r.vj = $urandom;
            r.vk = $urandom;
            r.rj = 1'($urandom_range(0, 1));
            r.rk = 1'($urandom_range(0, 1));
            r.qj = 8'($urandom_range(0, 3));
            r.qk = 8'($urandom_range(0, 3));
            r.dest = 8'($urandom);
            r.cv = $urandom_range(0, 9) < 4;
            r.ct = 8'($urandom_range(0, 3));
            r.cd = $urandom;
            r.dr = $urandom_range(0, 9) < 6;
            r.fl = $urandom_range(0, 99) < 3;
            step(r);
            #1;
            e_f = mq.size() == N;
            sel = -1;
            for (int k = 0; k < mq.size(); k++) begin
                rdy = (mq[k].rj || (BYP && r.cv && mq[k].qj == r.ct))
                   && (mq[k].rk || (BYP && r.cv && mq[k].qk == r.ct));
                if (rdy && sel < 0)
                    sel = k;
            end
            e_dv = sel >= 0 && !r.fl;
            if (e_dv) begin
                e = mq[sel];
                e_vj = e.rj ? e.vj : r.cd;
                e_vk = e.rk ? e.vk : r.cd;
                chk_out($sformatf("rnd%0d", c), e_f, 1'b1, e.op,
                        e.dest, e_vj, e_vk, e.a);
            end else begin
                chk_out($sformatf("rnd%0d", c), e_f, 1'b0, 0,
                        0, 0, 0, 0);
            end
            @(posedge clk);
            if (r.fl) begin
                mq.delete();
            end else begin
                ok_iss = r.iv && mq.size() < N;
                if (e_dv && r.dr)
                    mq.delete(sel);
                for (int k = 0; k < mq.size(); k++) begin
                    if (r.cv && !mq[k].rj && mq[k].qj == r.ct) begin
                        mq[k].rj = 1; mq[k].vj = r.cd;
                    end
                    if (r.cv && !mq[k].rk && mq[k].qk == r.ct) begin
                        mq[k].rk = 1; mq[k].vk = r.cd;
                    end
                end
                if (ok_iss) begin
                    ne.op = r.op; ne.dest = r.dest;
                    ne.a = 32'hA0 + {24'h0, r.dest};
                    ne.qj = r.qj; ne.qk = r.qk;
                    ne.rj = r.rj || (r.cv && r.qj == r.ct);
                    ne.rk = r.rk || (r.cv && r.qk == r.ct);
                    ne.vj = (!r.rj && r.cv && r.qj == r.ct) ? r.cd : r.vj;
                    ne.vk = (!r.rk && r.cv && r.qk == r.ct) ? r.cd : r.vk;
                    mq.push_back(ne);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
